// File: rtl/serial_comparator_if.sv
// Handshake/operand bundle for serial_comparator: the master issues start/a/b,
// the slave returns busy, the done pulse and the gt/lt/eq result flags.
interface serial_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;

  modport master (output start, a, b, input busy, done, gt, lt, eq);
  modport slave  (input start, a, b, output busy, done, gt, lt, eq);
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with a one-cycle done pulse.
// Define SERIAL_COMPARATOR_EARLY_EXIT_EN to finish on the first differing bit.
module serial_comparator #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_comparator_if.slave bus
);
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [IDX_W-1:0] idx_r;
  logic             decided_r;
  logic             dec_gt_r;
  logic             busy_r;
  logic             done_r;
  logic             gt_r;
  logic             lt_r;
  logic             eq_r;

  logic bit_a_s;
  logic bit_b_s;
  logic diff_s;
  logic dec_s;
  logic dec_gt_s;
  logic last_s;
  logic finish_s;

  // Single-bit compare on the current index; the first difference wins.
  always_comb begin
    bit_a_s = a_r[idx_r];
    bit_b_s = b_r[idx_r];
    diff_s  = ~decided_r & (bit_a_s ^ bit_b_s);
    dec_s   = decided_r | diff_s;
    if (decided_r) begin
      dec_gt_s = dec_gt_r;
    end else begin
      dec_gt_s = bit_a_s;
    end
    last_s = (idx_r == IDX_W'(0));
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
    finish_s = last_s | diff_s;
`else
    finish_s = last_s;
`endif
  end

  // Control FSM, operand shadow registers and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      idx_r     <= '0;
      decided_r <= 1'b0;
      dec_gt_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      gt_r      <= 1'b0;
      lt_r      <= 1'b0;
      eq_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            a_r       <= bus.a;
            b_r       <= bus.b;
            idx_r     <= IDX_W'(WIDTH - 1);
            decided_r <= 1'b0;
            dec_gt_r  <= 1'b0;
            busy_r    <= 1'b1;
            state_r   <= RUN;
          end else begin
            state_r   <= IDLE;
          end
        end
        RUN: begin
          decided_r <= dec_s;
          dec_gt_r  <= dec_gt_s;
          if (finish_s) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            gt_r    <= dec_s & dec_gt_s;
            lt_r    <= dec_s & ~dec_gt_s;
            eq_r    <= ~dec_s;
            state_r <= DONE;
          end else begin
            idx_r   <= idx_r - IDX_W'(1);
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.gt   = gt_r;
  assign bus.lt   = lt_r;
  assign bus.eq   = eq_r;
endmodule

// File: tb/tb_serial_comparator.sv
// Directed, table-driven bench for serial_comparator (WIDTH=8) plus hand-written
// sequences for start-during-RUN, back-to-back start and asynchronous reset.
module tb_serial_comparator;
  localparam int WIDTH = 8;
`ifdef SERIAL_COMPARATOR_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_comparator_if #(.WIDTH(WIDTH)) bus ();
  serial_comparator #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // lat = n where done is high in cycle T+n (T = edge sampling start)
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       gt;
    logic       lt;
    logic       eq;
    int         lat;
  } vec_t;

  vec_t vecs[10];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_cmp(input vec_t v, input bit glitch, input bit hold, input string tag);
    int lat;
    lat = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = v.a;
    bus.b     = v.b;
    @(posedge clk); #1;
    check($sformatf("%s busy", tag), {31'd0, bus.busy}, 32'd1);
    if (glitch) begin
      bus.a = 8'h10; bus.b = 8'h20; bus.start = 1'b1;
    end else begin
      bus.start = 1'b0;
    end
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (glitch && n == 1) bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = n + 1;
        break;
      end
    end
    check($sformatf("%s latency", tag), lat, v.lat);
    check($sformatf("%s gt", tag), {31'd0, bus.gt}, {31'd0, v.gt});
    check($sformatf("%s lt", tag), {31'd0, bus.lt}, {31'd0, v.lt});
    check($sformatf("%s eq", tag), {31'd0, bus.eq}, {31'd0, v.eq});
    check($sformatf("%s busy_at_done", tag), {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s done_pulse", tag), {31'd0, bus.done}, 32'd0);
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("%s hold", tag), {29'd0, bus.gt, bus.lt, bus.eq}, {29'd0, v.gt, v.lt, v.eq});
      check($sformatf("%s idle", tag), {30'd0, bus.busy, bus.done}, 32'd0);
    end
  endtask

  initial begin
    bit seen_done;
    vec_t v;
    vecs[0] = '{8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1, 9};
    vecs[1] = '{8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, EE ? 2 : 9};
    vecs[2] = '{8'h01, 8'h02, 1'b0, 1'b1, 1'b0, EE ? 8 : 9};
    vecs[3] = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, EE ? 2 : 9};
    vecs[4] = '{8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, EE ? 2 : 9};
    vecs[5] = '{8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 9};
    vecs[6] = '{8'hFE, 8'hFF, 1'b0, 1'b1, 1'b0, 9};
    vecs[7] = '{8'h37, 8'h35, 1'b1, 1'b0, 1'b0, EE ? 8 : 9};
    vecs[8] = '{8'h40, 8'h20, 1'b1, 1'b0, 1'b0, EE ? 3 : 9};
    vecs[9] = '{8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 9};

    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    rst       = 1'b1;
    #12;
    check("reset outputs", {27'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post-reset idle", {27'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      do_cmp(vecs[i], 1'b0, 1'b1, $sformatf("vec%0d", i));
    end

    // start pulsed during RUN is ignored; a new start right after done is accepted
    do_cmp(vecs[1], 1'b1, 1'b0, "glitch");
    do_cmp(vecs[2], 1'b0, 1'b1, "b2b");

    // asynchronous reset in the middle of a RUN
    @(negedge clk);
    bus.start = 1'b1; bus.a = 8'h5A; bus.b = 8'h5A;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async reset outputs", {27'd0, bus.busy, bus.done, bus.gt, bus.lt, bus.eq}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    check("no done after abort", {31'd0, seen_done}, 32'd0);
    v = '{8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, EE ? 2 : 9};
    do_cmp(v, 1'b0, 1'b1, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
